// File: rtl/prim_present_iter.sv
// prim_present_iter: iterative PRESENT block cipher core, encrypt or decrypt
// selected per request. RoundsPerCycle rounds are evaluated per clock; decrypt
// first walks the forward key schedule to recover the last round key, so the
// caller always hands in the original key. One operation in flight at a time.
module prim_present_iter #(
    parameter int DataWidth      = 64,
    parameter int KeyWidth       = 128,
    parameter int NumRounds      = 31,
    parameter int RoundsPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 dec_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [KeyWidth-1:0]  key_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o
);

    localparam int         NibbleCount = DataWidth / 4;
    // The 128-bit schedule mixes the round index in higher up than 64/80.
    localparam int         RcLsb       = (KeyWidth == 128) ? 62 : 15;
    localparam logic [4:0] RoundsTotal = 5'(NumRounds);
    localparam logic [4:0] RoundStep   = 5'(RoundsPerCycle);
    // Value of the round counter on the last iteration of a phase.
    localparam logic [4:0] LastRc      = 5'(NumRounds - RoundsPerCycle + 1);

    // Parameter sanity, caught at elaboration.
    if (!((DataWidth == 64 && (KeyWidth == 64 || KeyWidth == 80 || KeyWidth == 128)) ||
          (DataWidth == 32 && KeyWidth == 64))) begin : gen_bad_widths
        $error("prim_present_iter: unsupported DataWidth/KeyWidth combination");
    end
    if (NumRounds < 1 || NumRounds > 31) begin : gen_bad_rounds
        $error("prim_present_iter: NumRounds must be within 1..31");
    end
    if (RoundsPerCycle < 1 || (NumRounds % RoundsPerCycle) != 0) begin : gen_bad_unroll
        $error("prim_present_iter: RoundsPerCycle must be >= 1 and divide NumRounds");
    end

    // ------------------------------------------------------------------
    // Cipher primitives
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hc;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hb;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'ha;  4'h7: y = 4'hd;
            4'h8: y = 4'h3;  4'h9: y = 4'he;  4'ha: y = 4'hf;  4'hb: y = 4'h8;
            4'hc: y = 4'h4;  4'hd: y = 4'h7;  4'he: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'he;  4'h2: y = 4'hf;  4'h3: y = 4'h8;
            4'h4: y = 4'hc;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hd;
            4'h8: y = 4'hb;  4'h9: y = 4'h4;  4'ha: y = 4'h6;  4'hb: y = 4'h3;
            4'hc: y = 4'h0;  4'hd: y = 4'h7;  4'he: y = 4'h9;  default: y = 4'ha;
        endcase
        return y;
    endfunction

    function automatic logic [DataWidth-1:0] sbox_layer(input logic [DataWidth-1:0] x);
        logic [DataWidth-1:0] y;
        y = '0;
        for (int n = 0; n < NibbleCount; n++) begin
            y[4*n +: 4] = sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [DataWidth-1:0] sbox_inv_layer(input logic [DataWidth-1:0] x);
        logic [DataWidth-1:0] y;
        y = '0;
        for (int n = 0; n < NibbleCount; n++) begin
            y[4*n +: 4] = sbox4_inv(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to i*DataWidth/4 mod (DataWidth-1); the MSB stays put.
    function automatic logic [DataWidth-1:0] perm_fwd(input logic [DataWidth-1:0] x);
        logic [DataWidth-1:0] y;
        y = '0;
        for (int i = 0; i < DataWidth - 1; i++) begin
            y[(i * NibbleCount) % (DataWidth - 1)] = x[i];
        end
        y[DataWidth-1] = x[DataWidth-1];
        return y;
    endfunction

    function automatic logic [DataWidth-1:0] perm_inv(input logic [DataWidth-1:0] x);
        logic [DataWidth-1:0] y;
        y = '0;
        for (int i = 0; i < DataWidth - 1; i++) begin
            y[i] = x[(i * NibbleCount) % (DataWidth - 1)];
        end
        y[DataWidth-1] = x[DataWidth-1];
        return y;
    endfunction

    // Forward key update: rotate left by 61, S-box the top nibble(s), mix in round index.
    function automatic logic [KeyWidth-1:0] key_update(input logic [KeyWidth-1:0] k,
                                                       input logic [4:0]          r);
        logic [KeyWidth-1:0] o;
        o = (k << 61) | (k >> (KeyWidth - 61));
        o[KeyWidth-1 -: 4] = sbox4(o[KeyWidth-1 -: 4]);
        if (KeyWidth == 128) begin
            o[KeyWidth-5 -: 4] = sbox4(o[KeyWidth-5 -: 4]);
        end
        o[RcLsb +: 5] = o[RcLsb +: 5] ^ r;
        return o;
    endfunction

    // Inverse key update for decrypt round r, which undoes forward round NumRounds-r+1.
    function automatic logic [KeyWidth-1:0] key_update_inv(input logic [KeyWidth-1:0] k,
                                                           input logic [4:0]          r);
        logic [KeyWidth-1:0] o;
        o = k;
        o[RcLsb +: 5] = o[RcLsb +: 5] ^ (RoundsTotal - r + 5'd1);
        o[KeyWidth-1 -: 4] = sbox4_inv(o[KeyWidth-1 -: 4]);
        if (KeyWidth == 128) begin
            o[KeyWidth-5 -: 4] = sbox4_inv(o[KeyWidth-5 -: 4]);
        end
        o = (o >> 61) | (o << (KeyWidth - 61));
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e               state_reg, state_next;
    logic [DataWidth-1:0] data_reg, data_next;
    logic [KeyWidth-1:0]  key_reg, key_next;
    logic                 dec_reg, dec_next;
    logic [4:0]           rc_reg, rc_next;
    logic [DataWidth-1:0] out_reg, out_next;

    logic [DataWidth-1:0] enc_data, dec_data;
    logic [KeyWidth-1:0]  fwd_key, inv_key;

    // Unrolled round chain: RoundsPerCycle rounds starting at round index rc_reg.
    // The forward key chain serves both encryption and decrypt key expansion.
    always_comb begin
        enc_data = data_reg;
        dec_data = data_reg;
        fwd_key  = key_reg;
        inv_key  = key_reg;
        for (int i = 0; i < RoundsPerCycle; i++) begin
            enc_data = perm_fwd(sbox_layer(enc_data ^ fwd_key[KeyWidth-1 -: DataWidth]));
            fwd_key  = key_update(fwd_key, rc_reg + 5'(i));
            dec_data = sbox_inv_layer(perm_inv(dec_data ^ inv_key[KeyWidth-1 -: DataWidth]));
            inv_key  = key_update_inv(inv_key, rc_reg + 5'(i));
        end
    end

    // Next-state logic, datapath updates and handshake outputs.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        key_next   = key_reg;
        dec_next   = dec_reg;
        rc_next    = rc_reg;
        out_next   = out_reg;
        ready_o    = (state_reg == IDLE);
        valid_o    = (state_reg == DONE);

        if (clr_i) begin
            state_next = IDLE;
            rc_next    = 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        data_next  = data_i;
                        key_next   = key_i;
                        dec_next   = dec_i;
                        rc_next    = 5'd1;
                        state_next = dec_i ? KEYEXP : RUN;
                    end
                end
                KEYEXP: begin
                    key_next = fwd_key;
                    if (rc_reg == LastRc) begin
                        rc_next    = 5'd1;
                        state_next = RUN;
                    end else begin
                        rc_next = rc_reg + RoundStep;
                    end
                end
                RUN: begin
                    if (dec_reg) begin
                        data_next = dec_data;
                        key_next  = inv_key;
                    end else begin
                        data_next = enc_data;
                        key_next  = fwd_key;
                    end
                    if (rc_reg == LastRc) begin
                        // Final whitening with the key left after the last round.
                        out_next   = data_next ^ key_next[KeyWidth-1 -: DataWidth];
                        rc_next    = 5'd0;
                        state_next = DONE;
                    end else begin
                        rc_next = rc_reg + RoundStep;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: working block, key, direction, round counter, result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_reg <= '0;
            key_reg  <= '0;
            dec_reg  <= 1'b0;
            rc_reg   <= 5'd0;
            out_reg  <= '0;
        end else begin
            data_reg <= data_next;
            key_reg  <= key_next;
            dec_reg  <= dec_next;
            rc_reg   <= rc_next;
            out_reg  <= out_next;
        end
    end

    assign data_o = out_reg;

    // A result waiting for the consumer must not change under it.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (valid_o && !ready_i) |=> $stable(data_o));

    // Accepting and presenting are mutually exclusive.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(valid_o && ready_o));

endmodule

// File: tb/tb_prim_present_iter.sv
// tb_prim_present_iter: drives three configurations of the iterative PRESENT
// core (64/80 one round per clock, 64/128 fully unrolled, 32/64 with 12 rounds
// three per clock) and checks them against a round-key-table PRESENT model.
module tb_prim_present_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic         clr      [3];
    logic         valid_in [3];
    logic         dec_in   [3];
    logic         ready_in [3];
    logic [63:0]  data_in  [3];
    logic [127:0] key_in   [3];

    logic        a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
    logic [63:0] a_data, b_data;
    logic [31:0] c_data;

    int dw_t  [3] = '{64, 64, 32};
    int kw_t  [3] = '{80, 128, 64};
    int nr_t  [3] = '{31, 31, 12};
    int rpc_t [3] = '{1, 31, 3};

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prim_present_iter #(.DataWidth(64), .KeyWidth(80), .NumRounds(31), .RoundsPerCycle(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .valid_i(valid_in[0]), .ready_o(a_ready),
        .dec_i(dec_in[0]), .data_i(data_in[0]), .key_i(key_in[0][79:0]), .valid_o(a_valid),
        .ready_i(ready_in[0]), .data_o(a_data));

    prim_present_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(31), .RoundsPerCycle(31)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .valid_i(valid_in[1]), .ready_o(b_ready),
        .dec_i(dec_in[1]), .data_i(data_in[1]), .key_i(key_in[1]), .valid_o(b_valid),
        .ready_i(ready_in[1]), .data_o(b_data));

    prim_present_iter #(.DataWidth(32), .KeyWidth(64), .NumRounds(12), .RoundsPerCycle(3)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .valid_i(valid_in[2]), .ready_o(c_ready),
        .dec_i(dec_in[2]), .data_i(data_in[2][31:0]), .key_i(key_in[2][63:0]), .valid_o(c_valid),
        .ready_i(ready_in[2]), .data_o(c_data));

    function automatic logic obs_ready(input int i);
        case (i)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    function automatic logic obs_valid(input int i);
        case (i)
            0: return a_valid;
            1: return b_valid;
            default: return c_valid;
        endcase
    endfunction

    function automatic logic [63:0] obs_data(input int i);
        case (i)
            0: return a_data;
            1: return b_data;
            default: return {32'h0, c_data};
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x, input bit inv);
        logic [63:0] t;
        t = 64'hc56b90ad3ef84712;
        if (!inv) return t[(15 - int'(x)) * 4 +: 4];
        for (int y = 0; y < 16; y++) begin
            if (t[(15 - y) * 4 +: 4] == x) return 4'(y);
        end
        return 4'h0;
    endfunction

    function automatic logic [63:0] m_sbox_layer(input logic [63:0] d, input int dw, input bit inv);
        logic [63:0] o;
        o = '0;
        for (int j = 0; j < dw / 4; j++) o[4*j +: 4] = m_sbox(d[4*j +: 4], inv);
        return o;
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] d, input int dw, input bit inv);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < dw - 1; i++) begin
            if (!inv) o[(i * dw / 4) % (dw - 1)] = d[i];
            else      o[i] = d[(i * dw / 4) % (dw - 1)];
        end
        o[dw-1] = d[dw-1];
        return o;
    endfunction

    function automatic logic [127:0] m_key_update(input logic [127:0] k, input int kw, input int r);
        logic [127:0] o;
        logic [4:0]   rr;
        int           pos;
        o = '0;
        for (int i = 0; i < kw; i++) o[(i + 61) % kw] = k[i];
        o[kw-1 -: 4] = m_sbox(o[kw-1 -: 4], 1'b0);
        if (kw == 128) o[kw-5 -: 4] = m_sbox(o[kw-5 -: 4], 1'b0);
        rr = 5'(r);
        pos = (kw == 128) ? 62 : 15;
        o[pos +: 5] = o[pos +: 5] ^ rr;
        return o;
    endfunction

    // Full cipher from a precomputed table of round keys.
    function automatic logic [63:0] m_cipher(input int dw, input int kw, input int nr, input bit dec,
                                             input logic [63:0] din, input logic [127:0] kin);
        logic [63:0]  rk [32];
        logic [127:0] k;
        logic [63:0]  d, mask;
        mask = (dw == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        k = kin;
        for (int r = 1; r <= nr + 1; r++) begin
            rk[r-1] = 64'(k >> (kw - dw)) & mask;
            if (r <= nr) k = m_key_update(k, kw, r);
        end
        d = din & mask;
        if (!dec) begin
            for (int r = 0; r < nr; r++) d = m_perm(m_sbox_layer(d ^ rk[r], dw, 1'b0), dw, 1'b0);
            d = d ^ rk[nr];
        end else begin
            d = d ^ rk[nr];
            for (int r = nr - 1; r >= 0; r--) d = m_sbox_layer(m_perm(d, dw, 1'b1), dw, 1'b1) ^ rk[r];
        end
        return d;
    endfunction

    function automatic logic [63:0] rand_data(input int dw);
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        if (dw == 32) d[63:32] = 32'h0;
        return d;
    endfunction

    function automatic logic [127:0] rand_key(input int kw);
        logic [127:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (kw < 128) k = k & ((128'(1) << kw) - 128'(1));
        return k;
    endfunction

    // ---------------- stimulus drivers ----------------
    task automatic start_op(input int i, input logic dec, input logic [63:0] d, input logic [127:0] k);
        int n;
        @(negedge clk);
        valid_in[i] = 1'b1;
        dec_in[i]   = dec;
        data_in[i]  = d;
        key_in[i]   = k;
        n = 0;
        while (!obs_ready(i) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        valid_in[i] = 1'b0;
        dec_in[i]   = ~dec;
        data_in[i]  = {$urandom(), $urandom()};
        key_in[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_result(input int i, output int lat);
        lat = 0;
        while (!obs_valid(i) && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input int i);
        @(negedge clk);
        ready_in[i] = 1'b1;
        @(posedge clk);
        #1;
        ready_in[i] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_ready(i) !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready inst=%0d got=%b exp=1", i, obs_ready(i));
            end
            vectors++;
            if (obs_valid(i) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid inst=%0d got=%b exp=0", i, obs_valid(i));
            end
            vectors++;
            if (obs_data(i) !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_data inst=%0d got=%h exp=0", i, obs_data(i));
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_known_answer();
        logic [63:0] vin  [4] = '{64'h0, 64'h0, 64'h5579c1387b228445, 64'h96db702a2e6900af};
        logic [63:0] vexp [4] = '{64'h5579c1387b228445, 64'h96db702a2e6900af, 64'h0, 64'h0};
        int          vinst[4] = '{0, 1, 0, 1};
        int          vlat [4] = '{31, 1, 62, 2};
        int          lat;
        logic [63:0] res;
        for (int v = 0; v < 4; v++) begin
            start_op(vinst[v], v >= 2, vin[v], 128'h0);
            wait_result(vinst[v], lat);
            res = obs_data(vinst[v]);
            $display("kat inst=%0d dec=%0d in=%h -> %h latency=%0d", vinst[v], v >= 2, vin[v], res, lat);
            vectors++;
            if (res !== vexp[v]) begin
                miscompares++;
                $display("FAIL kat_data inst=%0d got=%h exp=%h", vinst[v], res, vexp[v]);
            end
            vectors++;
            if (lat !== vlat[v]) begin
                miscompares++;
                $display("FAIL kat_latency inst=%0d got=%0d exp=%0d", vinst[v], lat, vlat[v]);
            end
            ack(vinst[v]);
        end
    endtask

    task automatic test_roundtrip();
        logic [63:0]  d, ct, exp_ct, pt;
        logic [127:0] k;
        int           lat, c;
        for (int i = 0; i < 3; i++) begin
            c = nr_t[i] / rpc_t[i];
            for (int n = 0; n < 6; n++) begin
                d = rand_data(dw_t[i]);
                k = rand_key(kw_t[i]);
                exp_ct = m_cipher(dw_t[i], kw_t[i], nr_t[i], 1'b0, d, k);
                start_op(i, 1'b0, d, k);
                wait_result(i, lat);
                ct = obs_data(i);
                $display("enc inst=%0d pt=%h key=%h -> ct=%h latency=%0d", i, d, k, ct, lat);
                vectors++;
                if (ct !== exp_ct || lat !== c) begin
                    miscompares++;
                    $display("FAIL enc inst=%0d got=%h/%0d exp=%h/%0d", i, ct, lat, exp_ct, c);
                end
                ack(i);
                start_op(i, 1'b1, exp_ct, k);
                wait_result(i, lat);
                pt = obs_data(i);
                $display("dec inst=%0d ct=%h -> pt=%h latency=%0d", i, exp_ct, pt, lat);
                vectors++;
                if (pt !== d || lat !== 2 * c) begin
                    miscompares++;
                    $display("FAIL dec inst=%0d got=%h/%0d exp=%h/%0d", i, pt, lat, d, 2 * c);
                end
                ack(i);
            end
        end
    endtask

    task automatic test_done_hold();
        logic [63:0]  d, exp_ct;
        logic [127:0] k;
        int           lat, bad;
        d = rand_data(64);
        k = rand_key(80);
        exp_ct = m_cipher(64, 80, 31, 1'b0, d, k);
        start_op(0, 1'b0, d, k);
        wait_result(0, lat);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            valid_in[0] = 1'b1;
            data_in[0]  = {$urandom(), $urandom()};
            ready_in[0] = 1'b0;
            @(posedge clk);
            #1;
            if (a_valid !== 1'b1 || a_data !== exp_ct || a_ready !== 1'b0) bad++;
        end
        $display("hold inst=0 ct=%h held cycles=10 bad=%0d", a_data, bad);
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL done_hold got=%0d bad cycles exp=0 (valid=%b data=%h ready=%b want %h)",
                     bad, a_valid, a_data, a_ready, exp_ct);
        end
        @(negedge clk);
        valid_in[0] = 1'b0;
        ready_in[0] = 1'b1;
        @(posedge clk);
        #1;
        ready_in[0] = 1'b0;
        vectors++;
        if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_data !== exp_ct) begin
            miscompares++;
            $display("FAIL done_release got ready=%b valid=%b data=%h exp ready=1 valid=0 data=%h",
                     a_ready, a_valid, a_data, exp_ct);
        end
    endtask

    task automatic test_clear();
        logic [63:0]  prev, d, exp_ct;
        logic [127:0] k;
        int           seen, lat;
        prev = a_data;
        seen = 0;
        for (int phase = 0; phase < 2; phase++) begin
            start_op(0, phase == 0, rand_data(64), rand_key(80));
            repeat (phase == 0 ? 5 : 10) begin
                @(posedge clk);
                #1;
                if (a_valid) seen++;
            end
            @(negedge clk);
            clr[0] = 1'b1;
            valid_in[0] = 1'b1;
            @(posedge clk);
            #1;
            vectors++;
            if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_data !== prev) begin
                miscompares++;
                $display("FAIL clear_phase%0d got ready=%b valid=%b data=%h exp ready=1 valid=0 data=%h",
                         phase, a_ready, a_valid, a_data, prev);
            end
            @(negedge clk);
            clr[0] = 1'b0;
            valid_in[0] = 1'b0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (a_valid) seen++;
            end
            $display("clear phase=%0d inst=0 valid seen=%0d", phase, seen);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL clear_no_valid got=%0d exp=0", seen);
        end
        // clr in IDLE together with a request must not accept it
        @(negedge clk);
        clr[0] = 1'b1;
        valid_in[0] = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_idle_accept got ready=%b exp=1", a_ready);
        end
        @(negedge clk);
        clr[0] = 1'b0;
        valid_in[0] = 1'b0;
        d = rand_data(64);
        k = rand_key(80);
        exp_ct = m_cipher(64, 80, 31, 1'b0, d, k);
        start_op(0, 1'b0, d, k);
        wait_result(0, lat);
        $display("post-clear enc inst=0 pt=%h -> %h latency=%0d", d, a_data, lat);
        vectors++;
        if (a_data !== exp_ct || lat !== 31) begin
            miscompares++;
            $display("FAIL clear_recover got=%h/%0d exp=%h/31", a_data, lat, exp_ct);
        end
        ack(0);
    endtask

    task automatic test_async_reset();
        start_op(0, 1'b0, rand_data(64), rand_key(80));
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_ready(i) !== 1'b1 || obs_valid(i) !== 1'b0 || obs_data(i) !== 64'h0) begin
                miscompares++;
                $display("FAIL async_reset inst=%0d got ready=%b valid=%b data=%h exp 1/0/0",
                         i, obs_ready(i), obs_valid(i), obs_data(i));
            end
        end
        $display("async reset asserted mid-run");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [63:0]  d, exp_r;
        logic [127:0] k;
        logic         dec;
        int           lat, c;
        for (int i = 0; i < 3; i++) ready_in[i] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c = nr_t[i] / rpc_t[i];
            for (int n = 0; n < 4; n++) begin
                dec = n[0];
                d = rand_data(dw_t[i]);
                k = rand_key(kw_t[i]);
                exp_r = m_cipher(dw_t[i], kw_t[i], nr_t[i], dec, d, k);
                start_op(i, dec, d, k);
                wait_result(i, lat);
                $display("b2b inst=%0d dec=%0d in=%h -> %h latency=%0d", i, dec, d, obs_data(i), lat);
                vectors++;
                if (obs_data(i) !== exp_r || lat !== (dec ? 2 * c : c)) begin
                    miscompares++;
                    $display("FAIL back_to_back inst=%0d got=%h/%0d exp=%h/%0d",
                             i, obs_data(i), lat, exp_r, dec ? 2 * c : c);
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) ready_in[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            clr[i]      = 1'b0;
            valid_in[i] = 1'b0;
            dec_in[i]   = 1'b0;
            ready_in[i] = 1'b0;
            data_in[i]  = '0;
            key_in[i]   = '0;
        end
        test_reset();
        test_known_answer();
        test_roundtrip();
        test_done_hold();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
